// File: rtl/bus_pkg.sv
// Shared encodings for the three-way bus arbiter: mux select codes, FSM states
// and the index-to-grant decode.
package bus_pkg;

   localparam int NUM_REQ = 3;

   localparam logic [1:0] SEL_A = 2'h0;
   localparam logic [1:0] SEL_B = 2'h1;
   localparam logic [1:0] SEL_C = 2'h2;

   typedef enum logic {
      IDLE = 1'b0,
      OWN  = 1'b1
   } state_e;

   function automatic logic [NUM_REQ-1:0] onehot3(input logic [1:0] idx);
      logic [NUM_REQ-1:0] oh;
      case (idx)
         SEL_A:   oh = 3'b001;
         SEL_B:   oh = 3'b010;
         SEL_C:   oh = 3'b100;
         default: oh = 3'b000;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/grant bundle between the arbiter (master side) and the requesters
// (slave side).
interface bus_arbiter_if;

   logic [bus_pkg::NUM_REQ-1:0] Req;
   logic [bus_pkg::NUM_REQ-1:0] Grant;
   logic [1:0]                  Select;
   logic                        Busy;
   logic                        Timeout;

   modport master (
      input  Req,
      output Grant,
      output Select,
      output Busy,
      output Timeout
   );

   modport slave (
      output Req,
      input  Grant,
      input  Select,
      input  Busy,
      input  Timeout
   );

endinterface

// File: rtl/bus_arbiter_rr_pick3.sv
// Combinational round-robin picker: first set request scanning from the
// requester after LastOwner, wrapping modulo three.
module rr_pick3
   import bus_pkg::*;
(
   input  logic [NUM_REQ-1:0] Req,
   input  logic [1:0]         LastOwner,
   output logic [1:0]         Pick,
   output logic               Valid
);

   logic [1:0] ord0, ord1, ord2;

   always_comb begin
      case (LastOwner)
         SEL_A:   begin ord0 = SEL_B; ord1 = SEL_C; ord2 = SEL_A; end
         SEL_B:   begin ord0 = SEL_C; ord1 = SEL_A; ord2 = SEL_B; end
         default: begin ord0 = SEL_A; ord1 = SEL_B; ord2 = SEL_C; end
      endcase
   end

   always_comb begin
      Pick  = SEL_A;
      Valid = 1'b1;
      if (Req[ord0])      Pick = ord0;
      else if (Req[ord1]) Pick = ord1;
      else if (Req[ord2]) Pick = ord2;
      else                Valid = 1'b0;
   end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner FSM for the shared 16-bit bus: one idle turnaround cycle
// between owners and a hold limit that only bites while someone else waits.
module bus_arbiter
   import bus_pkg::*;
#(
   parameter int MAX_HOLD = 8,
   parameter int CNT_W    = 4
) (
   input logic           Clk,
   input logic           Reset_n,
   bus_arbiter_if.master bus
);

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

   state_e               state_q, state_d;
   logic [1:0]           last_q, last_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [NUM_REQ-1:0]   grant_q, grant_d;
   logic [1:0]           select_q, select_d;
   logic                 busy_q, busy_d;
   logic                 timeout_q, timeout_d;

   logic [1:0]           pick;
   logic                 pick_vld;
   logic                 owner_req;
   logic                 others_req;
   logic                 preempt;

   rr_pick3 u_pick (
      .Req       (bus.Req),
      .LastOwner (last_q),
      .Pick      (pick),
      .Valid     (pick_vld)
   );

   assign owner_req  = bus.Req[select_q];
   assign others_req = |(bus.Req & ~grant_q);
   // A dropping owner always wins over the hold limit, so Timeout stays quiet then.
   assign preempt    = owner_req && (cnt_q == HOLD_LAST) && others_req;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q   <= IDLE;
         last_q    <= SEL_C;
         cnt_q     <= '0;
         grant_q   <= '0;
         select_q  <= SEL_A;
         busy_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         cnt_q     <= cnt_d;
         grant_q   <= grant_d;
         select_q  <= select_d;
         busy_q    <= busy_d;
         timeout_q <= timeout_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (pick_vld) state_d = OWN;
         OWN:     if (!owner_req || preempt) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      grant_d   = '0;
      select_d  = SEL_A;
      busy_d    = 1'b0;
      timeout_d = 1'b0;
      cnt_d     = cnt_q;
      last_d    = last_q;
      case (state_q)
         IDLE: begin
            if (pick_vld) begin
               grant_d  = onehot3(pick);
               select_d = pick;
               busy_d   = 1'b1;
               cnt_d    = '0;
               last_d   = pick;
            end
         end
         OWN: begin
            if (!owner_req) begin
               cnt_d = '0;
            end else if (preempt) begin
               cnt_d     = '0;
               timeout_d = 1'b1;
            end else begin
               grant_d  = grant_q;
               select_d = select_q;
               busy_d   = 1'b1;
               cnt_d    = (cnt_q == HOLD_LAST) ? cnt_q : cnt_q + 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign bus.Grant   = grant_q;
   assign bus.Select  = select_q;
   assign bus.Busy    = busy_q;
   assign bus.Timeout = timeout_q;

endmodule
